// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// shift_seq_ctrl: one-command-per-start sequencer for a 74194-style 8-bit shift register.
// Optional SHIFT_ROTATE_EN: cmd 11 rotates down by N (sr = q[0]); otherwise cmd 11 is a no-op.
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             cp,
   input  logic             cr,
   input  logic             start,
   input  logic [1:0]       cmd,
   input  logic [CNT_W-1:0] cnt,
   input  logic [WIDTH-1:0] din,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] q,
   output logic             s1,
   output logic             s0,
   output logic [WIDTH-1:0] d,
   output logic             sr,
   output logic             sl,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             s1_q;
   logic             s0_q;
   logic [WIDTH-1:0] d_q;
   logic             sr_q;
   logic             sl_q;
   logic             busy_q;
   logic             done_q;
   logic             bypass;

`ifdef SHIFT_ROTATE_EN
   logic             rot_q;
   assign bypass = (cnt == '0);
`else
   logic             unused_q;
   assign unused_q = ^q;
   assign bypass   = (cnt == '0) || (cmd == 2'b11);
`endif

   always_ff @(posedge cp or posedge cr) begin
      if (cr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         s1_q    <= 1'b0;
         s0_q    <= 1'b0;
         d_q     <= '0;
         sr_q    <= 1'b0;
         sl_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (cmd == 2'b00) begin
                     state_q <= ST_LOAD;
                     s1_q    <= 1'b1;
                     s0_q    <= 1'b1;
                     d_q     <= din;
                  end else if (bypass) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     // cmd 01 and rotate (11) both use mode 01; cmd 10 uses mode 10
                     state_q <= ST_SHIFT;
                     cnt_q   <= cnt;
                     s1_q    <= (cmd == 2'b10);
                     s0_q    <= cmd[0];
                     sr_q    <= ser_in;
                     sl_q    <= ser_in;
`ifdef SHIFT_ROTATE_EN
                     rot_q   <= (cmd == 2'b11);
`endif
                  end
               end
            end
            ST_LOAD: begin
               state_q <= ST_DONE;
               s1_q    <= 1'b0;
               s0_q    <= 1'b0;
               d_q     <= '0;
               done_q  <= 1'b1;
            end
            ST_SHIFT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_DONE;
                  s1_q    <= 1'b0;
                  s0_q    <= 1'b0;
                  sr_q    <= 1'b0;
                  sl_q    <= 1'b0;
                  done_q  <= 1'b1;
`ifdef SHIFT_ROTATE_EN
                  rot_q   <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s1   = s1_q;
   assign s0   = s0_q;
   assign d    = d_q;
   assign sl   = sl_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SHIFT_ROTATE_EN
   // Rotate feeds the bit leaving Q[0] straight back in at Q[7]
   assign sr   = rot_q ? q[0] : sr_q;
`else
   assign sr   = sr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// tb_shift_seq_ctrl: directed and random commands against an arithmetic model of the final register value.
module tb_shift_seq_ctrl;

   logic       cp = 1'b0;
   logic       cr = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [3:0] cnt = 4'd0;
   logic [7:0] din = 8'h00;
   logic       ser_in = 1'b0;
   logic [7:0] q_reg = 8'h00;
   logic       s1, s0, sr, sl, busy, done;
   logic [7:0] d;

   int checks   = 0;
   int failures = 0;

   shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .cp(cp), .cr(cr), .start(start), .cmd(cmd), .cnt(cnt), .din(din),
      .ser_in(ser_in), .q(q_reg), .s1(s1), .s0(s0), .d(d), .sr(sr), .sl(sl),
      .busy(busy), .done(done)
   );

   always #5 cp = ~cp;

   // 74194-style register driven by the sequencer; cr does not touch it
   always @(posedge cp) begin
      case ({s1, s0})
         2'b11:   q_reg <= d;
         2'b01:   q_reg <= {sr, q_reg[7:1]};
         2'b10:   q_reg <= {q_reg[6:0], sl};
         default: q_reg <= q_reg;
      endcase
   end

`ifdef SHIFT_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cp);
      #1;
   endtask

   function automatic logic [7:0] model_q(input logic [7:0] q0, input logic [1:0] c,
                                          input logic [3:0] n, input logic [7:0] dv, input logic f);
      logic [7:0]  ones;
      logic [15:0] dbl;
      ones = 8'hFF;
      dbl  = {q0, q0};
      case (c)
         2'b00:   return dv;
         2'b01:   return (q0 >> n) | (f ? ~(ones >> n) : 8'h00);
         2'b10:   return (q0 << n) | (f ? ~(ones << n) : 8'h00);
         default: return ROT ? 8'(dbl >> (n % 8)) : q0;
      endcase
   endfunction

   task automatic run_cmd(input string tag, input logic [1:0] c, input logic [3:0] n,
                          input logic [7:0] dv, input logic f, input int poke);
      logic [7:0] exp_q;
      logic [1:0] exp_mode;
      int         exp_lat, exp_modes, lat, modes;
      bit         shifting, outs_ok;
      shifting  = (c == 2'b01) || (c == 2'b10) || ((c == 2'b11) && ROT);
      exp_q     = model_q(q_reg, c, n, dv, f);
      exp_mode  = (c == 2'b00) ? 2'b11 : (c == 2'b10) ? 2'b10 : 2'b01;
      exp_lat   = (c == 2'b00) ? 2 : (shifting && n != 0) ? n + 1 : 1;
      exp_modes = (c == 2'b00) ? 1 : shifting ? n : 0;
      start = 1'b1; cmd = c; cnt = n; din = dv; ser_in = f;
      tick();
      start = 1'b0;
      cmd = 2'($urandom); cnt = 4'($urandom); din = 8'($urandom); ser_in = 1'($urandom);
      modes   = 0;
      outs_ok = 1'b1;
      for (lat = 1; lat <= 40; lat++) begin
         if (!busy) outs_ok = 1'b0;
         if ({s1, s0} != 2'b00) begin
            if ({s1, s0} == exp_mode) modes++;
            else outs_ok = 1'b0;
         end
         if (d !== (({s1, s0} == 2'b11) ? dv : 8'h00)) outs_ok = 1'b0;
         if ({s1, s0} == 2'b01 || {s1, s0} == 2'b10) begin
            if (sl !== f) outs_ok = 1'b0;
            if (sr !== ((c == 2'b11) ? q_reg[0] : f)) outs_ok = 1'b0;
         end else if ({sr, sl} !== 2'b00) outs_ok = 1'b0;
         if (done) break;
         if (lat == poke) begin
            start = 1'b1; cmd = 2'b00; din = 8'($urandom);
         end else start = 1'b0;
         tick();
      end
      start = 1'b0;
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".mode_cycles"}, modes, exp_modes);
      chk({tag, ".outputs"}, outs_ok, 1);
      tick();
      chk({tag, ".idle_after"}, {done, busy}, 2'b00);
      chk({tag, ".q"}, q_reg, exp_q);
   endtask

   initial begin
      #2;
      chk("reset.outputs", {s1, s0, d, sr, sl, busy, done}, 0);
      tick(); tick();
      chk("reset.held", {s1, s0, d, sr, sl, busy, done}, 0);
      cr = 1'b0;
      tick();

      run_cmd("t1_load_a5", 2'b00, 4'd0, 8'hA5, 1'b0, 0);
      run_cmd("t2_prep", 2'b00, 4'd0, 8'h00, 1'b0, 0);
      run_cmd("t2_down3", 2'b01, 4'd3, 8'h00, 1'b1, 0);
      chk("t2_value", q_reg, 8'hE0);
      run_cmd("t3_prep", 2'b00, 4'd0, 8'h01, 1'b0, 0);
      run_cmd("t3_up0", 2'b10, 4'd0, 8'h00, 1'b1, 0);
      run_cmd("t4_up5_poke", 2'b10, 4'd5, 8'h00, 1'b1, 3);
      run_cmd("t4b_up15", 2'b10, 4'd15, 8'h00, 1'b0, 1);

      // Reset two steps into a six-step shift
      run_cmd("t5_prep", 2'b00, 4'd0, 8'h00, 1'b0, 0);
      start = 1'b1; cmd = 2'b01; cnt = 4'd6; ser_in = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      cr = 1'b1;
      #1;
      chk("t5.outputs_cleared", {s1, s0, d, sr, sl, busy, done}, 0);
      chk("t5.q_partial", q_reg, 8'hC0);
      tick();
      chk("t5.q_held", q_reg, 8'hC0);
      cr = 1'b0;
      tick();
      run_cmd("t5_after", 2'b01, 4'd2, 8'h00, 1'b0, 0);

      run_cmd("t6_prep", 2'b00, 4'd0, 8'h81, 1'b0, 0);
      run_cmd("t6_cmd11", 2'b11, 4'd1, 8'h00, 1'b0, 0);
      chk("t6_value", q_reg, ROT ? 8'hC0 : 8'h81);

      for (int i = 0; i < 24; i++) begin
         run_cmd($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
